// File: rtl/tlul_sram_responder.sv
// tlul_sram_responder: TL-UL slave endpoint backed by a small word-addressed
// register memory. Handles Get / PutFullData / PutPartialData with a single
// outstanding transaction and returns AccessAck / AccessAckData.
// Optional feature macro: TLUL_RESP_LATENCY_EN adds a WAIT state that delays
// the D-channel response by RESP_LATENCY extra cycles.
module tlul_sram_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    localparam int                   MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    DEPTH        = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int                    RESP_LATENCY = 2
) (
    input  logic                    clk_24,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic                    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic                    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int LANE_SHIFT = $clog2(MASK_WIDTH);
    localparam int IDX_W      = $clog2(DEPTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] D_ACK       = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] D_ACK_DATA  = OPCODE_WIDTH'(1);

    // One past the last mapped byte; one extra bit so the limit cannot wrap.
    localparam logic [ADDR_WIDTH:0] END_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(DEPTH * MASK_WIDTH);

`ifdef TLUL_RESP_LATENCY_EN
    localparam int CNT_W = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic {IDLE, RESP} state_t;
`endif

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  is_get;
    logic                  op_err;
    logic                  size_err;
    logic                  align_err;
    logic                  range_err;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      word_idx;
    logic                  unused_ok;

    assign a_ready = (state_q == IDLE);
    assign d_valid = (state_q == RESP);
    assign d_param = '0;
    assign d_sink  = 1'b0;

    assign accept = a_valid && a_ready;
    assign is_get = (a_opcode == OP_GET);

    // Request decode: legality of opcode, size, alignment and address window.
    assign op_err     = !(a_opcode == OP_PUT_FULL || a_opcode == OP_PUT_PART || is_get);
    assign size_err   = (a_size > SIZE_WIDTH'(LANE_SHIFT));
    assign align_mask = (ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1);
    assign align_err  = |(a_address & align_mask);
    assign range_err  = (a_address < BASE_ADDR) || ({1'b0, a_address} >= END_ADDR);
    assign acc_err    = op_err || size_err || align_err || range_err;

    assign offset   = a_address - BASE_ADDR;
    assign word_idx = offset[LANE_SHIFT +: IDX_W];

`ifdef TLUL_RESP_LATENCY_EN
    assign unused_ok = ^{a_param, offset};
`else
    assign unused_ok = ^{a_param, offset, 1'(RESP_LATENCY)};
`endif

    // State register (and latency counter when enabled).
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
`ifdef TLUL_RESP_LATENCY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef TLUL_RESP_LATENCY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, optional delay in WAIT, handshake in RESP.
    always_comb begin
        state_d = state_q;
`ifdef TLUL_RESP_LATENCY_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (a_valid) begin
`ifdef TLUL_RESP_LATENCY_EN
                    if (RESP_LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RESP_LATENCY);
                    end
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef TLUL_RESP_LATENCY_EN
            WAIT: begin
                // The count reaching zero coincides with entering RESP.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                if (d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response payload is captured at accept and held until the handshake.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            d_opcode <= '0;
            d_size   <= '0;
            d_source <= 1'b0;
            d_data   <= '0;
            d_error  <= 1'b0;
        end else if (accept) begin
            d_opcode <= is_get ? D_ACK_DATA : D_ACK;
            d_size   <= a_size;
            d_source <= a_source;
            d_error  <= acc_err;
            d_data   <= (is_get && !acc_err) ? mem[word_idx] : '0;
        end
    end

    // Memory: cleared on reset, byte-lane writes for legal Puts at accept.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (accept && !acc_err && !is_get) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (a_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Testbench for tlul_sram_responder: directed transactions with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the memory and response timing.
`timescale 1ns/1ps
module tb_tlul_sram_responder;

`ifdef TLUL_RESP_LATENCY_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk_24 = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;

    int checks = 0;
    int errors = 0;

    tlul_sram_responder dut (
        .clk_24    (clk_24),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_data    (d_data),
        .d_error   (d_error)
    );

    always #5 clk_24 = ~clk_24;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus the one pending response.
    logic [31:0] exp_mem [16];
    bit          m_busy = 1'b0;
    int          m_due  = 0;
    int          cyc    = 0;
    logic [2:0]  m_op   = 3'd0;
    logic [2:0]  m_size = 3'd0;
    logic        m_src  = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic        m_err  = 1'b0;
    logic        mo_err;
    int          mo_idx;

    always @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                if (cyc >= m_due && d_ready) m_busy = 1'b0;
            end else if (a_valid) begin
                mo_err = !(a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4)
                         || a_size > 3'd2
                         || (a_address % (32'd1 << a_size)) != 32'd0
                         || a_address < 32'h1000
                         || a_address >= 32'h1040;
                m_op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
                m_size = a_size;
                m_src  = a_source;
                m_err  = mo_err;
                m_data = 32'd0;
                if (!mo_err) begin
                    mo_idx = int'((a_address - 32'h1000) / 4);
                    if (a_opcode == 3'd4) begin
                        m_data = exp_mem[mo_idx];
                    end else begin
                        for (int i = 0; i < 4; i++)
                            if (a_mask[i]) exp_mem[mo_idx][8*i +: 8] = a_data[8*i +: 8];
                    end
                end
                m_busy = 1'b1;
                m_due  = cyc + 1 + EXTRA;
            end
            cyc++;
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk_24) begin
        logic exp_v;
        if (!reset_n) begin
            chk("rst_d_valid",  64'(d_valid),  64'h0);
            chk("rst_d_opcode", 64'(d_opcode), 64'h0);
            chk("rst_d_size",   64'(d_size),   64'h0);
            chk("rst_d_source", 64'(d_source), 64'h0);
            chk("rst_d_data",   64'(d_data),   64'h0);
            chk("rst_d_error",  64'(d_error),  64'h0);
            chk("rst_d_param",  64'(d_param),  64'h0);
            chk("rst_d_sink",   64'(d_sink),   64'h0);
        end else begin
            exp_v = m_busy && (cyc >= m_due);
            chk("a_ready", 64'(a_ready), 64'(!m_busy));
            chk("d_valid", 64'(d_valid), 64'(exp_v));
            if (exp_v) begin
                chk("d_opcode", 64'(d_opcode), 64'(m_op));
                chk("d_size",   64'(d_size),   64'(m_size));
                chk("d_source", 64'(d_source), 64'(m_src));
                chk("d_data",   64'(d_data),   64'(m_data));
                chk("d_error",  64'(d_error),  64'(m_err));
                chk("d_param",  64'(d_param),  64'h0);
                chk("d_sink",   64'(d_sink),   64'h0);
            end
        end
    end

    // One complete transaction; d_ready held low for 'hold' cycles of valid response.
    task automatic xact(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input int hold,
                        output logic [2:0] r_op, output logic [31:0] r_data,
                        output logic r_err, output int lat);
        int t;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = size;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_param   = 3'($urandom);
        a_source  = 1'($urandom);
        t = 0;
        while (!a_ready && t < 50) begin
            @(posedge clk_24); #1;
            t++;
        end
        chk("accept_wait", 64'(a_ready), 64'h1);
        @(posedge clk_24); #1;
        a_valid = 1'b0;
        lat = 1;
        while (!d_valid && lat < 20) begin
            @(posedge clk_24); #1;
            lat++;
        end
        chk("resp_wait", 64'(d_valid), 64'h1);
        repeat (hold) begin
            @(posedge clk_24); #1;
        end
        r_op   = d_opcode;
        r_data = d_data;
        r_err  = d_error;
        d_ready = 1'b1;
        @(posedge clk_24); #1;
        d_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_data;
        logic        r_err;
        int          lat;
        int          t;
        int          pick;
        int          r;

        reset_n = 1'b0;
        a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0; a_source = 1'b0;
        a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0; d_ready = 1'b0;
        repeat (3) @(posedge clk_24);
        #1 reset_n = 1'b1;

        xact(3'd0, 3'd2, 32'h1000, 4'hF, 32'hA5A5_A5A5, 0, r_op, r_data, r_err, lat);
        chk("put_full_opcode", 64'(r_op), 64'h0);
        chk("put_full_error", 64'(r_err), 64'h0);
        chk("put_full_latency", 64'(lat), 64'(1 + EXTRA));
        xact(3'd4, 3'd2, 32'h1000, 4'h0, 32'h0, 0, r_op, r_data, r_err, lat);
        chk("get_1000_opcode", 64'(r_op), 64'h1);
        chk("get_1000_data", 64'(r_data), 64'hA5A5_A5A5);

        xact(3'd1, 3'd2, 32'h1004, 4'h5, 32'h1122_3344, 0, r_op, r_data, r_err, lat);
        xact(3'd4, 3'd2, 32'h1004, 4'hF, 32'h0, 0, r_op, r_data, r_err, lat);
        chk("get_partial_data", 64'(r_data), 64'h0022_0044);

        xact(3'd4, 3'd2, 32'h2000, 4'hF, 32'h0, 0, r_op, r_data, r_err, lat);
        chk("oob_get_opcode", 64'(r_op), 64'h1);
        chk("oob_get_error", 64'(r_err), 64'h1);
        chk("oob_get_data", 64'(r_data), 64'h0);

        xact(3'd0, 3'd2, 32'h1002, 4'hF, 32'hFFFF_FFFF, 0, r_op, r_data, r_err, lat);
        chk("misaligned_put_opcode", 64'(r_op), 64'h0);
        chk("misaligned_put_error", 64'(r_err), 64'h1);
        xact(3'd4, 3'd2, 32'h1000, 4'hF, 32'h0, 0, r_op, r_data, r_err, lat);
        chk("misaligned_no_write", 64'(r_data), 64'hA5A5_A5A5);

        xact(3'd0, 3'd2, 32'h103C, 4'hF, 32'hDEAD_BEEF, 0, r_op, r_data, r_err, lat);
        xact(3'd4, 3'd2, 32'h103C, 4'hF, 32'h0, 5, r_op, r_data, r_err, lat);
        chk("stalled_get_data", 64'(r_data), 64'hDEAD_BEEF);
        xact(3'd4, 3'd2, 32'h1004, 4'hF, 32'h0, 0, r_op, r_data, r_err, lat);
        chk("accept_after_stall", 64'(r_data), 64'h0022_0044);

        // Reset while a response is pending.
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_address = 32'h1000; a_mask = 4'hF;
        t = 0;
        while (!a_ready && t < 50) begin
            @(posedge clk_24); #1;
            t++;
        end
        @(posedge clk_24); #1;
        a_valid = 1'b0;
        t = 0;
        while (!d_valid && t < 20) begin
            @(posedge clk_24); #1;
            t++;
        end
        chk("pre_reset_d_valid", 64'(d_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_d_valid", 64'(d_valid), 64'h0);
        repeat (2) @(posedge clk_24);
        #1 reset_n = 1'b1;
        chk("post_reset_a_ready", 64'(a_ready), 64'h1);
        xact(3'd4, 3'd2, 32'h1000, 4'hF, 32'h0, 0, r_op, r_data, r_err, lat);
        chk("post_reset_mem_cleared", 64'(r_data), 64'h0);

        // Randomized traffic.
        repeat (3000) begin
            @(posedge clk_24); #1;
            a_valid  = 1'($urandom_range(0, 1));
            d_ready  = ($urandom_range(0, 3) != 0);
            a_source = 1'($urandom);
            a_param  = 3'($urandom);
            a_data   = $urandom;
            a_mask   = 4'($urandom);
            r = $urandom_range(0, 7);
            if (r < 2)      a_opcode = 3'd0;
            else if (r < 4) a_opcode = 3'd1;
            else if (r < 7) a_opcode = 3'd4;
            else            a_opcode = 3'($urandom);
            pick = $urandom_range(0, 9);
            if (pick < 7) begin
                a_size    = 3'd2;
                a_address = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            end else if (pick < 9) begin
                a_size    = 3'($urandom_range(0, 3));
                a_address = 32'h1000 + 32'($urandom_range(0, 'h4F));
            end else begin
                a_size    = 3'($urandom);
                a_address = ($urandom_range(0, 1) != 0) ? 32'h0FFC : 32'h1040 + 32'(4 * $urandom_range(0, 7));
            end
        end
        @(posedge clk_24); #1;
        a_valid = 1'b0;
        d_ready = 1'b1;
        repeat (10) @(posedge clk_24);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
